// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller: per-digit hex/dp/blank registers,
// slot-based anode scanning with guard band, PWM dimming and a frame tick.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int GUARD      = 2,
  parameter int PWM_BITS   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] i_wr_digit,
  input  logic [3:0]                    i_wr_nibble,
  input  logic                          i_wr_dp,
  input  logic                          i_wr_blank,
  input  logic [NUM_DIGITS-1:0]         i_digit_en,
  input  logic [PWM_BITS-1:0]           i_brightness,
  output logic [NUM_DIGITS-1:0]         o_an,
  output logic [6:0]                    o_seg,
  output logic                          o_dp,
  output logic                          o_frame_tick
);

  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] GUARD_END = SLOT_W'(GUARD);

  logic [3:0]          nibble_reg [NUM_DIGITS];
  logic                dp_reg     [NUM_DIGITS];
  logic                blank_reg  [NUM_DIGITS];
  logic [IDX_W-1:0]    idx_reg;
  logic [SLOT_W-1:0]   slot_cnt_reg;
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic [NUM_DIGITS-1:0] an_reg;
  logic [6:0]          seg_reg;
  logic                dp_out_reg;
  logic                tick_reg;

  logic                  lit;
  logic [6:0]            seg_on;
  logic [NUM_DIGITS-1:0] an_next;
  logic                  slot_wrap;
  logic                  frame_wrap;

  // Indices >= NUM_DIGITS match no register, so out-of-range writes fall through.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      always_ff @(posedge clk) begin
        if (rst) begin
          nibble_reg[gi] <= 4'h0;
          dp_reg[gi]     <= 1'b0;
          blank_reg[gi]  <= 1'b1;
        end else if (i_wr_en && (i_wr_digit == IDX_W'(gi))) begin
          nibble_reg[gi] <= i_wr_nibble;
          dp_reg[gi]     <= i_wr_dp;
          blank_reg[gi]  <= i_wr_blank;
        end
      end

      assign an_next[gi] = ~(lit && (idx_reg == IDX_W'(gi)));
    end
  endgenerate

  assign slot_wrap  = (slot_cnt_reg == SLOT_LAST);
  assign frame_wrap = slot_wrap && (idx_reg == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_reg <= '0;
      idx_reg      <= '0;
      pwm_cnt_reg  <= '0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
      if (slot_wrap) begin
        slot_cnt_reg <= '0;
        idx_reg      <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end else begin
        slot_cnt_reg <= slot_cnt_reg + 1'b1;
      end
    end
  end

  // The guard band at the start of each slot lets the previous anode turn off before segments change.
  always_comb begin
    lit = (slot_cnt_reg >= GUARD_END) && i_digit_en[idx_reg] && !blank_reg[idx_reg]
          && (pwm_cnt_reg <= i_brightness);
  end

  always_comb begin
    seg_on = 7'h00;
    case (nibble_reg[idx_reg])
      4'h0: seg_on = 7'h7E;
      4'h1: seg_on = 7'h30;
      4'h2: seg_on = 7'h6D;
      4'h3: seg_on = 7'h79;
      4'h4: seg_on = 7'h33;
      4'h5: seg_on = 7'h5B;
      4'h6: seg_on = 7'h5F;
      4'h7: seg_on = 7'h70;
      4'h8: seg_on = 7'h7F;
      4'h9: seg_on = 7'h7B;
      4'hA: seg_on = 7'h77;
      4'hB: seg_on = 7'h1F;
      4'hC: seg_on = 7'h4E;
      4'hD: seg_on = 7'h3D;
      4'hE: seg_on = 7'h4F;
      default: seg_on = 7'h47;
    endcase
  end

  // Anodes, segments and dp share one register stage so a digit change never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_reg     <= '1;
      seg_reg    <= 7'h7F;
      dp_out_reg <= 1'b1;
      tick_reg   <= 1'b0;
    end else begin
      an_reg     <= an_next;
      seg_reg    <= lit ? ~seg_on : 7'h7F;
      dp_out_reg <= lit ? ~dp_reg[idx_reg] : 1'b1;
      tick_reg   <= frame_wrap;
    end
  end

  assign o_an         = an_reg;
  assign o_seg        = seg_reg;
  assign o_dp         = dp_out_reg;
  assign o_frame_tick = tick_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (8 digits, 8-cycle slots, guard 2, 2-bit PWM)
// plus a 9-digit instance used for out-of-range write indices.
module tb_seg7_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_digit = '0;
  logic [3:0] wr_nibble = '0;
  logic       wr_dp = 1'b0;
  logic       wr_blank = 1'b1;
  logic [7:0] digit_en = 8'hFF;
  logic [1:0] brightness = 2'd3;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  logic       wr9_en = 1'b0;
  logic [3:0] wr9_digit = '0;
  logic [8:0] en9 = 9'h1FF;
  logic [8:0] an9;
  logic [6:0] seg9;
  logic       dp9;
  logic       tick9;

  int n_cmp = 0;
  int n_bad = 0;
  int edges = 0;

  always #5 clk = ~clk;

  // Bench-side cycle reference: phase of the outputs visible at a negedge is edges-1.
  always @(posedge clk) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  seg7_scan_ctrl #(.NUM_DIGITS(8), .SCAN_DIV(8), .GUARD(2), .PWM_BITS(2)) dut (
    .clk(clk), .rst(rst), .i_wr_en(wr_en), .i_wr_digit(wr_digit),
    .i_wr_nibble(wr_nibble), .i_wr_dp(wr_dp), .i_wr_blank(wr_blank),
    .i_digit_en(digit_en), .i_brightness(brightness),
    .o_an(an), .o_seg(seg), .o_dp(dp), .o_frame_tick(frame_tick)
  );

  seg7_scan_ctrl #(.NUM_DIGITS(9), .SCAN_DIV(8), .GUARD(2), .PWM_BITS(2)) dut9 (
    .clk(clk), .rst(rst), .i_wr_en(wr9_en), .i_wr_digit(wr9_digit),
    .i_wr_nibble(wr_nibble), .i_wr_dp(wr_dp), .i_wr_blank(wr_blank),
    .i_digit_en(en9), .i_brightness(brightness),
    .o_an(an9), .o_seg(seg9), .o_dp(dp9), .o_frame_tick(tick9)
  );

  task step;
    @(negedge clk);
  endtask

  task wait_to(input int p);
    step;
    while (((edges - 1) % 64) != p) step;
  endtask

  task write8(input logic [2:0] d, input logic [3:0] nib, input logic dpv, input logic blk);
    wr_en = 1'b1; wr_digit = d; wr_nibble = nib; wr_dp = dpv; wr_blank = blk;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task write9(input logic [3:0] d, input logic [3:0] nib);
    wr9_en = 1'b1; wr9_digit = d; wr_nibble = nib; wr_dp = 1'b0; wr_blank = 1'b0;
    @(posedge clk);
    #1 wr9_en = 1'b0;
  endtask

  task test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    step;
    n_cmp++;
    if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || frame_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: an=%h seg=%h dp=%b tick=%b, want an=FF seg=7F dp=1 tick=0",
               an, seg, dp, frame_tick);
    end
    rst = 1'b0;
    for (int i = 0; i < 128; i++) begin
      step;
      n_cmp++;
      if (an !== 8'hFF) begin
        n_bad++;
        $display("FAIL blank_after_reset phase %0d: an=%h want FF", edges - 1, an);
      end
    end
  endtask

  task test_display;
    brightness = 2'd3;
    digit_en = 8'hFF;
    write8(3'd3, 4'hA, 1'b1, 1'b0);
    wait_to(24);
    for (int c = 0; c < 16; c++) begin
      logic [7:0] ea;
      logic [6:0] es;
      logic       ed;
      ea = (c >= 2 && c < 8) ? 8'hF7 : 8'hFF;
      es = (c >= 2 && c < 8) ? 7'h08 : 7'h7F;
      ed = (c >= 2 && c < 8) ? 1'b0 : 1'b1;
      n_cmp++;
      if (an !== ea || seg !== es || dp !== ed) begin
        n_bad++;
        $display("FAIL slot3_display cyc %0d: an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                 c, an, seg, dp, ea, es, ed);
      end
      step;
    end
  endtask

  task test_pwm;
    for (int b = 0; b < 4; b++) begin
      brightness = 2'(b);
      wait_to(26);
      for (int c = 26; c < 32; c++) begin
        logic [7:0] ea;
        logic [6:0] es;
        ea = ((c % 4) <= b) ? 8'hF7 : 8'hFF;
        es = ((c % 4) <= b) ? 7'h08 : 7'h7F;
        n_cmp++;
        if (an !== ea || seg !== es) begin
          n_bad++;
          $display("FAIL pwm b=%0d phase %0d: an=%h seg=%h, want an=%h seg=%h",
                   b, c, an, seg, ea, es);
        end
        step;
      end
    end
    brightness = 2'd3;
  endtask

  task test_frame_tick;
    int pulses;
    pulses = 0;
    for (int i = 0; i < 130; i++) begin
      step;
      if (frame_tick === 1'b1) pulses++;
      n_cmp++;
      if (frame_tick !== (((edges - 1) % 64) == 63)) begin
        n_bad++;
        $display("FAIL frame_tick phase %0d: tick=%b want %b",
                 edges - 1, frame_tick, (((edges - 1) % 64) == 63));
      end
    end
    n_cmp++;
    if (pulses < 2 || pulses > 3) begin
      n_bad++;
      $display("FAIL frame_tick_count: got %0d pulses in 130 cycles, want 2..3", pulses);
    end
    digit_en = 8'hF7;
    wait_to(24);
    for (int c = 0; c < 8; c++) begin
      n_cmp++;
      if (an !== 8'hFF) begin
        n_bad++;
        $display("FAIL digit_en_off cyc %0d: an=%h want FF", c, an);
      end
      step;
    end
    digit_en = 8'hFF;
  endtask

  task test_back_to_back;
    int lit_cnt;
    int bad_val;
    wait_to(28);
    n_cmp++;
    if (an !== 8'hF7 || seg !== 7'h08 || dp !== 1'b0) begin
      n_bad++;
      $display("FAIL midslot_before: an=%h seg=%h dp=%b, want F7 08 0", an, seg, dp);
    end
    write8(3'd3, 4'h5, 1'b1, 1'b0);
    step;
    n_cmp++;
    if (an !== 8'hF7 || seg !== 7'h08) begin
      n_bad++;
      $display("FAIL midslot_write_edge: an=%h seg=%h, want F7 08", an, seg);
    end
    step;
    n_cmp++;
    if (an !== 8'hF7 || seg !== 7'h24 || dp !== 1'b0) begin
      n_bad++;
      $display("FAIL midslot_after: an=%h seg=%h dp=%b, want F7 24 0", an, seg, dp);
    end

    write9(4'd9, 4'h8);
    lit_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      step;
      if (an9 !== 9'h1FF) lit_cnt++;
    end
    n_cmp++;
    if (lit_cnt != 0) begin
      n_bad++;
      $display("FAIL out_of_range_write: %0d lit cycles, want 0", lit_cnt);
    end

    write9(4'd8, 4'h8);
    lit_cnt = 0;
    bad_val = 0;
    for (int i = 0; i < 72; i++) begin
      step;
      if (an9 !== 9'h1FF) begin
        lit_cnt++;
        if (an9 !== 9'h0FF || seg9 !== 7'h00) bad_val++;
      end
    end
    n_cmp++;
    if (lit_cnt != 6 || bad_val != 0) begin
      n_bad++;
      $display("FAIL top_index_write: %0d lit cycles (%0d wrong), want 6 (0 wrong)", lit_cnt, bad_val);
    end
  endtask

  task test_mid_reset;
    write8(3'd5, 4'h1, 1'b0, 1'b0);
    wait_to(44);
    n_cmp++;
    if (an !== 8'hDF || seg !== 7'h4F) begin
      n_bad++;
      $display("FAIL slot5_lit: an=%h seg=%h, want DF 4F", an, seg);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    step;
    n_cmp++;
    if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || frame_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: an=%h seg=%h dp=%b tick=%b, want FF 7F 1 0",
               an, seg, dp, frame_tick);
    end
    write8(3'd0, 4'h8, 1'b0, 1'b0);
    for (int c = 0; c < 64; c++) begin
      logic [7:0] ea;
      logic [6:0] es;
      step;
      ea = (c >= 2 && c < 8) ? 8'hFE : 8'hFF;
      es = (c >= 2 && c < 8) ? 7'h00 : 7'h7F;
      n_cmp++;
      if (an !== ea || seg !== es) begin
        n_bad++;
        $display("FAIL post_reset_scan phase %0d: an=%h seg=%h, want an=%h seg=%h",
                 c, an, seg, ea, es);
      end
    end
  endtask

  initial begin
    test_reset;
    test_display;
    test_pwm;
    test_frame_tick;
    test_back_to_back;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
